// File: rtl/preload_writer.sv
// preload_writer: parses 7-byte framed write commands from a byte stream into regfile/RAM writes.
// Keeps the CPU in reset until a frame flagged "last" has been written, then parks in DONE until start.
module preload_writer #(
  parameter int ERR_W  = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              active,
  output logic              hold_cpu,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic [3:0] {
    S_CMD, S_AHI, S_ALO, S_D3, S_D2, S_D1, S_D0, S_WRITE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic        hs;
  logic        tgt_ram;
  logic        last_frame;
  logic        rsv_bad;
  logic [11:0] addr;
  logic [23:0] data_hi;
  logic        frame_ok;

  assign hs       = in_valid && in_ready;
  assign active   = (state != S_DONE);
  assign hold_cpu = active;
  assign done     = (state == S_DONE);

  // r0 is hard-wired, and the regfile only has 32 entries.
  assign frame_ok = !rsv_bad && (tgt_ram || ((addr[11:5] == 7'd0) && (addr[4:0] != 5'd0)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_CMD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_CMD: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_AHI;
      end
      S_AHI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_ALO;
      end
      S_ALO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_D3;
      end
      S_D3: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_D2;
      end
      S_D2: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_D1;
      end
      S_D1: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_D0;
      end
      S_D0: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_WRITE;
      end
      S_WRITE: state_nxt = last_frame ? S_DONE : S_CMD;
      S_DONE:  if (start) state_nxt = S_CMD;
      default: state_nxt = S_CMD;
    endcase
  end

  // Write strobes are set on the D0 handshake, so they are high for exactly the WRITE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      tgt_ram    <= 1'b0;
      last_frame <= 1'b0;
      rsv_bad    <= 1'b0;
      addr       <= '0;
      data_hi    <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err_count  <= '0;
    end else begin
      rf_we  <= 1'b0;
      mem_we <= 1'b0;
      if (hs) begin
        case (state)
          S_CMD: begin
            tgt_ram    <= in_data[7];
            last_frame <= in_data[6];
            rsv_bad    <= (in_data[5:0] != 6'd0);
          end
          S_AHI: addr[11:8]      <= in_data[3:0];
          S_ALO: addr[7:0]       <= in_data;
          S_D3:  data_hi[23:16]  <= in_data;
          S_D2:  data_hi[15:8]   <= in_data;
          S_D1:  data_hi[7:0]    <= in_data;
          S_D0: begin
            if (frame_ok) begin
              rf_we     <= !tgt_ram;
              mem_we    <= tgt_ram;
              rf_waddr  <= addr[4:0];
              rf_wdata  <= {data_hi, in_data};
              mem_addr  <= ADDR_W'(addr);
              mem_wdata <= {data_hi, in_data};
            end else if (err_count != {ERR_W{1'b1}}) begin
              err_count <= err_count + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_preload_writer.sv
// Randomised bench for preload_writer: frames are scored against a frame-level model of
// accepted writes and rejected-frame count.
module tb_preload_writer;

  localparam int ERR_W  = 8;
  localparam int ADDR_W = 12;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              active;
  logic              hold_cpu;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              done;
  logic [ERR_W-1:0]  err_count;

  always #5 clock = ~clock;

  preload_writer #(.ERR_W(ERR_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .active(active), .hold_cpu(hold_cpu),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .err_count(err_count)
  );

  // Write record: {is_ram, addr[11:0], data[31:0]}
  typedef logic [44:0] wr_t;
  wr_t exp_q[$];
  wr_t obs_q[$];
  int  n_checks  = 0;
  int  n_err     = 0;
  int  model_err = 0;
  logic [55:0] frames[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (rf_we)  obs_q.push_back({1'b0, 7'd0, rf_waddr, rf_wdata});
      if (mem_we) obs_q.push_back({1'b1, mem_addr, mem_wdata});
      if (rf_we || mem_we) begin
        check("we_active", active, 1);
        check("we_in_ready", in_ready, 0);
        check("we_onehot", rf_we & mem_we, 0);
      end
    end
  end

  // Frame-level reference: decide accept/reject from the frame rules and record the outcome.
  task automatic model_frame(input logic [55:0] f, output bit acc);
    logic [7:0]  c = f[55:48];
    logic [11:0] a = {f[43:40], f[39:32]};
    acc = (c[5:0] == 6'd0) && (c[7] || (a >= 12'd1 && a <= 12'd31));
    if (acc) exp_q.push_back({c[7], a, f[31:0]});
    else if (model_err < ERR_MAX) model_err++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int t = 0;
    bit hs = 0;
    in_valid = 1'b0;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clock); #1; end
    in_valid = 1'b1;
    in_data  = b;
    while (!hs && t < 200) begin
      @(negedge clock);
      hs = in_ready;
      @(posedge clock); #1;
      t++;
    end
    check("hs_ok", hs, 1);
  endtask

  task automatic send_frame(input logic [55:0] f, input int gap_max);
    bit acc;
    model_frame(f, acc);
    for (int i = 0; i < 7; i++) send_byte(f[55 - 8*i -: 8], gap_max);
    in_valid = 1'b0;
    check("wr_pulse", {rf_we, mem_we}, acc ? (f[55] ? 2'b01 : 2'b10) : 2'b00);
    check("wr_rdy", in_ready, 0);
    check("err_cnt", err_count, model_err);
    if (f[54]) begin
      @(posedge clock); #1;
      check("done_st", {done, active, hold_cpu, in_ready}, 4'b1000);
    end
  endtask

  task automatic compare_writes(input string tag);
    @(negedge clock); #1;
    check({tag, "_n"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; start = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    model_err = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic idle_in_done(input int n);
    in_valid = 1'b1;
    in_data  = 8'hC0;
    repeat (n) begin
      @(negedge clock);
      check("done_rdy", in_ready, 0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic rearm();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("rearm", {active, hold_cpu, done, in_ready}, 4'b1101);
  endtask

  function automatic logic [55:0] rand_frame(input bit last);
    logic [7:0]  c;
    logic [11:0] a;
    c[7]   = 1'($urandom_range(0, 1));
    c[6]   = last;
    c[5:0] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
    a      = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 31));
    return {c, 4'($urandom), a, 32'($urandom)};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    do_reset();
    check("rst_ctl", {active, hold_cpu, in_ready, done, rf_we, mem_we}, 6'b111000);
    check("rst_addr", {rf_waddr, mem_addr}, 0);
    check("rst_data", {rf_wdata, mem_wdata}, 0);
    check("rst_err", err_count, 0);

    // Register preload, ending in DONE.
    send_frame(56'h00_00_05_DEADBEEF, 0);
    send_frame(56'h40_00_06_0000002A, 0);
    compare_writes("reg");
    idle_in_done(5);
    compare_writes("done_idle");
    rearm();

    // RAM preload
    send_frame(56'hC0_0A_BC_00000100, 0);
    compare_writes("ram");
    rearm();

    // Rejections
    send_frame(56'h00_00_20_11111111, 0);
    check("rej_addr32", err_count, 1);
    send_frame(56'h00_00_00_22222222, 0);
    check("rej_r0", err_count, 2);
    send_frame(56'h01_00_07_33333333, 0);
    check("rej_rsv", err_count, 3);
    compare_writes("rej");

    // Random frames, gap-free then with random gaps.
    for (int i = 0; i < 30; i++) frames.push_back(rand_frame(i == 29));
    foreach (frames[i]) send_frame(frames[i], 0);
    compare_writes("rnd_nogap");
    rearm();
    foreach (frames[i]) send_frame(frames[i], 3);
    compare_writes("rnd_gap");
    rearm();

    // Reset after 4 bytes of a frame.
    for (int i = 0; i < 4; i++) send_byte(8'h00 + 8'(i == 2 ? 8'h0B : 8'h00), 0);
    do_reset();
    send_frame(56'h40_00_09_CAFEF00D, 0);
    compare_writes("midrst");
    rearm();

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      case (i % 3)
        0:       send_frame({1'b0, i == 299, 6'd0, 8'h00, 8'h20, 32'(i)}, 0);
        1:       send_frame({1'b0, i == 299, 6'd0, 8'h00, 8'h00, 32'(i)}, 0);
        default: send_frame({1'b1, i == 299, 6'd4, 8'h01, 8'h23, 32'(i)}, 0);
      endcase
    end
    check("sat", err_count, ERR_MAX);
    compare_writes("sat_wr");

    // Re-arm from DONE keeps the error count.
    idle_in_done(4);
    rearm();
    send_frame(56'hC0_0F_FF_A5A5A5A5, 0);
    compare_writes("rearm_wr");
    check("rearm_err", err_count, ERR_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
